// File: rtl/mem_pkg.sv
// Shared types and constants for the memory/FIFO controller and display decode.
package mem_pkg;

    typedef enum logic {
        MODE_RAM  = 1'b0,
        MODE_FIFO = 1'b1
    } mode_t;

    // Segment patterns indexed by hex digit; bit7 unused, bits 6..0 = g..a.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

// File: rtl/hex7seg.sv
// Registered hex digit to seven-segment decoder; reset shows digit 0.
module hex7seg
    import mem_pkg::*;
(
    input  logic       clk_2,
    input  logic       reset,
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            seg <= SEG_TABLE[0];
        end else begin
            seg <= SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Small memory usable as an addressed RAM or as a FIFO, driven by switch-level
// write/read requests that are edge-detected so a held switch acts once.
module mem_fifo_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [7:0]            seg
);

    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  mode_q;
    logic                  wr_en_q;
    logic                  rd_en_q;

    logic wr_pulse;
    logic rd_pulse;
    logic mode_chg;
    logic fifo_mode;
    logic do_wr;
    logic do_rd;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    always_comb begin
        wr_pulse  = wr_en & ~wr_en_q;
        rd_pulse  = rd_en & ~rd_en_q;
        mode_chg  = (mode != mode_q);
        fifo_mode = (mode_t'(mode) == MODE_FIFO);
        do_rd     = rd_pulse & ~empty;
        // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
        do_wr     = wr_pulse & (~full | do_rd);
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            mode_q    <= mode;
        end else begin
            wr_en_q <= wr_en;
            rd_en_q <= rd_en;
            mode_q  <= mode;
            if (mode_chg) begin
                wptr      <= '0;
                rptr      <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else if (fifo_mode) begin
                if (do_wr) begin
                    mem[wptr] <= wdata;
                    wptr      <= wptr + PTR_ONE;
                end
                if (do_rd) begin
                    rdata <= mem[rptr];
                    rptr  <= rptr + PTR_ONE;
                end
                case ({do_wr, do_rd})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
                if (wr_pulse & full & ~rd_pulse) begin
                    overflow <= 1'b1;
                end
                if (rd_pulse & empty) begin
                    underflow <= 1'b1;
                end
            end else begin
                if (wr_pulse) begin
                    mem[addr] <= wdata;
                end else begin
                    rdata <= mem[addr];
                end
            end
        end
    end

    hex7seg u_hex7seg (
        .clk_2 (clk_2),
        .reset (reset),
        .digit (rdata[3:0]),
        .seg   (seg)
    );

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed self-checking bench for mem_fifo_ctrl (DATA_WIDTH 4, DEPTH 4).
module tb_mem_fifo_ctrl;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       mode;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;
    logic [7:0] seg;

    int vectors    = 0;
    int miscompares = 0;

    mem_fifo_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .mode      (mode),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .seg       (seg)
    );

    always #5 clk_2 = ~clk_2;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic push_pop(input logic [3:0] d);
        wdata = d;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (rdata !== 4'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        vectors++;
        if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
        vectors++;
        if ({full, empty, overflow, underflow} !== 4'b0100) begin
            miscompares++; $display("FAIL reset_flags got %b exp 0100", {full, empty, overflow, underflow});
        end
        vectors++;
        if (seg !== 8'h3F) begin miscompares++; $display("FAIL reset_seg got %h exp 3f", seg); end
    endtask

    task automatic ram_write(input logic [1:0] a, input logic [3:0] d);
        addr = a;
        push(d);
    endtask

    task automatic test_ram();
        ram_write(2'd2, 4'h5);
        ram_write(2'd3, 4'h9);
        addr = 2'd2;
        tick();
        vectors++;
        if (rdata !== 4'h5) begin miscompares++; $display("FAIL ram_rd_a2 got %h exp 5", rdata); end
        tick();
        vectors++;
        if (seg !== 8'h6D) begin miscompares++; $display("FAIL ram_seg_a2 got %h exp 6d", seg); end
        addr = 2'd3;
        tick();
        vectors++;
        if (rdata !== 4'h9) begin miscompares++; $display("FAIL ram_rd_a3 got %h exp 9", rdata); end
        tick();
        vectors++;
        if (seg !== 8'h6F) begin miscompares++; $display("FAIL ram_seg_a3 got %h exp 6f", seg); end
        // write to the address being read: old value in the write cycle, new one after
        wdata = 4'h4;
        wr_en = 1'b1;
        tick();
        vectors++;
        if (rdata !== 4'h9) begin miscompares++; $display("FAIL ram_wr_hold got %h exp 9", rdata); end
        wr_en = 1'b0;
        tick();
        vectors++;
        if (rdata !== 4'h4) begin miscompares++; $display("FAIL ram_wr_new got %h exp 4", rdata); end
        vectors++;
        if ({count, empty} !== 4'b0001) begin miscompares++; $display("FAIL ram_fifo_state got %b exp 0001", {count, empty}); end
    endtask

    task automatic test_fifo_basic();
        logic [3:0] exp_vals [4];
        exp_vals = '{4'h1, 4'h2, 4'h3, 4'h4};
        mode = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(exp_vals[i]);
        vectors++;
        if ({full, count} !== 4'b1100) begin miscompares++; $display("FAIL fifo_full got %b exp 1100", {full, count}); end
        push(4'h7);
        vectors++;
        if ({overflow, count} !== 4'b1100) begin miscompares++; $display("FAIL fifo_overflow got %b exp 1100", {overflow, count}); end
        for (int i = 0; i < 4; i++) begin
            pop();
            vectors++;
            if (rdata !== exp_vals[i]) begin miscompares++; $display("FAIL fifo_pop%0d got %h exp %h", i, rdata, exp_vals[i]); end
        end
        vectors++;
        if ({empty, count} !== 4'b1000) begin miscompares++; $display("FAIL fifo_empty got %b exp 1000", {empty, count}); end
        vectors++;
        if (seg !== 8'h66) begin miscompares++; $display("FAIL fifo_seg got %h exp 66", seg); end
    endtask

    task automatic test_underflow();
        pop();
        vectors++;
        if ({underflow, rdata} !== 5'b10100) begin miscompares++; $display("FAIL underflow_pop got %b exp 10100", {underflow, rdata}); end
        push_pop(4'h5);
        vectors++;
        if ({underflow, count} !== 4'b1001) begin miscompares++; $display("FAIL empty_push_pop got %b exp 1001", {underflow, count}); end
        vectors++;
        if (rdata !== 4'h4) begin miscompares++; $display("FAIL empty_push_pop_rdata got %h exp 4", rdata); end
        // leave and re-enter FIFO mode to clear pointers and flags
        mode = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        vectors++;
        if ({count, overflow, underflow} !== 5'b00000) begin
            miscompares++; $display("FAIL mode_toggle_clear got %b exp 00000", {count, overflow, underflow});
        end
    endtask

    task automatic test_wrap();
        logic [3:0] wvals [4];
        wvals = '{4'hA, 4'hB, 4'hC, 4'hD};
        for (int i = 1; i <= 3; i++) push(4'(i));
        for (int i = 1; i <= 3; i++) begin
            pop();
            vectors++;
            if (rdata !== 4'(i)) begin miscompares++; $display("FAIL wrap_pre_pop%0d got %h exp %h", i, rdata, 4'(i)); end
        end
        for (int i = 0; i < 4; i++) push(wvals[i]);
        vectors++;
        if ({full, count} !== 4'b1100) begin miscompares++; $display("FAIL wrap_full got %b exp 1100", {full, count}); end
        for (int i = 0; i < 4; i++) begin
            pop();
            vectors++;
            if (rdata !== wvals[i]) begin miscompares++; $display("FAIL wrap_pop%0d got %h exp %h", i, rdata, wvals[i]); end
        end
        vectors++;
        if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty got %b exp 1", empty); end
    endtask

    task automatic test_held_write();
        wdata = 4'h6;
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (count !== 3'd1) begin miscompares++; $display("FAIL held_wr_count got %0d exp 1", count); end
        wr_en = 1'b0;
        tick();
        vectors++;
        if (count !== 3'd1) begin miscompares++; $display("FAIL held_wr_release got %0d exp 1", count); end
    endtask

    task automatic test_back_to_back();
        push(4'h7);
        push_pop(4'h8);
        vectors++;
        if ({count, rdata} !== 7'b010_0110) begin miscompares++; $display("FAIL mid_push_pop got %b exp 0100110", {count, rdata}); end
        push(4'h9);
        push(4'hA);
        vectors++;
        if ({full, count} !== 4'b1100) begin miscompares++; $display("FAIL b2b_full got %b exp 1100", {full, count}); end
        push_pop(4'hB);
        vectors++;
        if ({count, overflow, rdata} !== 8'b100_0_0111) begin
            miscompares++; $display("FAIL full_push_pop got %b exp 10000111", {count, overflow, rdata});
        end
    endtask

    task automatic test_mode_change();
        push(4'hF);
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL pre_toggle_ovf got %b exp 1", overflow); end
        pop();
        vectors++;
        if (rdata !== 4'h8) begin miscompares++; $display("FAIL pre_toggle_pop1 got %h exp 8", rdata); end
        pop();
        vectors++;
        if ({count, overflow, rdata} !== 8'b010_1_1001) begin
            miscompares++; $display("FAIL pre_toggle_state got %b exp 01011001", {count, overflow, rdata});
        end
        mode = 1'b0;
        addr = 2'd0;
        tick();
        vectors++;
        if ({count, empty, overflow, underflow} !== 6'b000100) begin
            miscompares++; $display("FAIL toggle_clear got %b exp 000100", {count, empty, overflow, underflow});
        end
        tick();
        vectors++;
        if (rdata !== 4'hB) begin miscompares++; $display("FAIL ram_keep_a0 got %h exp b", rdata); end
        tick();
        vectors++;
        if (seg !== 8'h7C) begin miscompares++; $display("FAIL ram_keep_seg got %h exp 7c", seg); end
    endtask

    task automatic test_reset_mid();
        wdata = 4'hE;
        wr_en = 1'b1;
        reset = 1'b1;
        tick(); tick();
        wr_en = 1'b0;
        reset = 1'b0;
        tick();
        vectors++;
        if ({rdata, count, overflow, underflow} !== 9'b0) begin
            miscompares++; $display("FAIL mid_reset_state got %b exp 000000000", {rdata, count, overflow, underflow});
        end
        vectors++;
        if (seg !== 8'h3F) begin miscompares++; $display("FAIL mid_reset_seg got %h exp 3f", seg); end
        addr = 2'd0;
        tick(); tick();
        vectors++;
        if (rdata !== 4'h0) begin miscompares++; $display("FAIL mid_reset_mem got %h exp 0", rdata); end
        addr = 2'd1;
        tick();
        vectors++;
        if (rdata !== 4'h0) begin miscompares++; $display("FAIL mid_reset_mem1 got %h exp 0", rdata); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_fifo_basic();
        test_underflow();
        test_wrap();
        test_held_write();
        test_back_to_back();
        test_mode_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
